iot_event_arbiter: RTL and testbench

Upstream feeder for the active-device counter. It watches the on/off status level of N_DEV IoT devices and detects each status change. It serialises the changes through an arbiter into at most one event per clock, so the counter never misses simultaneous connects or disconnects. It drives the counter's change/on_off inputs directly and exposes the acknowledged device mask.

---
 rtl/iot_pkg.sv | 15 +
 rtl/iot_rr_arbiter.sv | 44 ++++
 rtl/iot_event_arbiter.sv | 74 +++++++
 tb/tb_iot_event_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_pkg.sv
// Shared constants and types for the IoT event arbiter slice.
// Default device count and the id-width derivation used by all modules.
package iot_pkg;

   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int N_DEV_DEF = 8;
   localparam int ID_W_DEF  = id_width(N_DEV_DEF);

   typedef logic [N_DEV_DEF-1:0] dev_mask_t;
   typedef logic [ID_W_DEF-1:0]  dev_id_t;

endpackage

// File: rtl/iot_rr_arbiter.sv
// Combinational single-grant arbiter over the pending-device vector.
// IOT_ARB_RR_EN selects round-robin from ptr+1; otherwise lowest index wins.
module iot_rr_arbiter
   import iot_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEF,
   parameter int ID_W  = id_width(N_DEV)
) (
   input  logic [N_DEV-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             gnt_valid,
   output logic [ID_W-1:0]  gnt_idx
);

`ifdef IOT_ARB_RR_EN
   // Walk the search order backwards so the last hit is the first in order.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = N_DEV; i >= 1; i--) begin
         if (req[(int'(ptr) + i) % N_DEV]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ID_W'((int'(ptr) + i) % N_DEV);
         end
      end
   end
`else
   logic ptr_unused;
   assign ptr_unused = ^ptr;

   // NOTE: every output gets a default first, so no path leaves a latch.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = N_DEV - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ID_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/iot_event_arbiter.sv
// Serialises device on/off status changes into one change event per clock.
// Arbitration policy: define IOT_ARB_RR_EN for round-robin, else fixed priority.
module iot_event_arbiter
   import iot_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEF,
   parameter int ID_W  = id_width(N_DEV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] dev_on,
   input  logic             en,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic [N_DEV-1:0] active_mask,
   output logic             pending_any
);

   logic [N_DEV-1:0] dev_s;
   logic [N_DEV-1:0] pending;
   logic             gnt_valid;
   logic [ID_W-1:0]  gnt_idx;
   logic [ID_W-1:0]  ptr;

   // A difference, not an edge queue: a toggle that returns before grant cancels.
   assign pending     = dev_s ^ active_mask;
   assign pending_any = |pending;

`ifdef IOT_ARB_RR_EN
   // Reset to the last index so the first search after reset starts at device 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= ID_W'(N_DEV - 1);
      end else if (en && gnt_valid) begin
         ptr <= gnt_idx;
      end
   end
`else
   assign ptr = '0;
`endif

   iot_rr_arbiter #(
      .N_DEV (N_DEV),
      .ID_W  (ID_W)
   ) u_arb (
      .req       (pending),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dev_s       <= '0;
         active_mask <= '0;
         change      <= 1'b0;
         on_off      <= 1'b0;
         dev_id      <= '0;
      end else begin
         dev_s <= dev_on;
         if (en && gnt_valid) begin
            change               <= 1'b1;
            on_off               <= dev_s[gnt_idx];
            dev_id               <= gnt_idx;
            active_mask[gnt_idx] <= dev_s[gnt_idx];
         end else begin
            change <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed self-checking bench for iot_event_arbiter (N_DEV = 8).
// Policy-dependent expectations follow IOT_ARB_RR_EN.
module tb_iot_event_arbiter;
   import iot_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   dev_mask_t dev_on;
   logic      en;
   logic      change;
   logic      on_off;
   dev_id_t   dev_id;
   dev_mask_t active_mask;
   logic      pending_any;

   int compared   = 0;
   int mismatched = 0;

   iot_event_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .dev_on      (dev_on),
      .en          (en),
      .change      (change),
      .on_off      (on_off),
      .dev_id      (dev_id),
      .active_mask (active_mask),
      .pending_any (pending_any)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive all devices off and wait (bounded) until nothing is pending.
   task automatic settle();
      logic settled;
      settled = 1'b0;
      en      = 1'b1;
      dev_on  = '0;
      for (int i = 0; i < 40 && !settled; i++) begin
         tick();
         if (i > 0 && !pending_any && !change) settled = 1'b1;
      end
      compared++;
      if (settled !== 1'b1) begin
         mismatched++;
         $display("FAIL settle: pending_any=%b change=%b, required idle within 40 cycles", pending_any, change);
      end
      compared++;
      if (active_mask !== 8'h00) begin
         mismatched++;
         $display("FAIL settle_mask: got %h, required 00", active_mask);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; dev_on = '0;
      #12 rst = 1'b0;
      dev_on = 8'hFF;
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      compared++;
      if ({change, on_off, dev_id, active_mask, pending_any} !== '0) begin
         mismatched++;
         $display("FAIL reset_async: change=%b on_off=%b dev_id=%0d mask=%h pend=%b, required all 0",
                  change, on_off, dev_id, active_mask, pending_any);
      end
      #1 rst = 1'b0;
      tick();
      compared++;
      if (change !== 1'b0 || pending_any !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_first_edge: change=%b pend=%b, required change=0 pend=1", change, pending_any);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         compared++;
         if (change !== 1'b1 || on_off !== 1'b1 || dev_id !== dev_id_t'(i)) begin
            mismatched++;
            $display("FAIL reset_rereport[%0d]: change=%b on_off=%b dev_id=%0d, required 1/1/%0d",
                     i, change, on_off, dev_id, i);
         end
      end
      tick();
      compared++;
      if (change !== 1'b0 || active_mask !== 8'hFF || pending_any !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_final: change=%b mask=%h pend=%b, required 0/FF/0", change, active_mask, pending_any);
      end
   endtask

   task automatic test_single();
      settle();
      dev_on = 8'h08;
      tick();
      compared++;
      if (change !== 1'b0) begin
         mismatched++;
         $display("FAIL single_early: change=%b, required 0", change);
      end
      tick();
      compared++;
      if (change !== 1'b1 || on_off !== 1'b1 || dev_id !== 3'd3) begin
         mismatched++;
         $display("FAIL single_event: change=%b on_off=%b dev_id=%0d, required 1/1/3", change, on_off, dev_id);
      end
      tick();
      compared++;
      if (change !== 1'b0 || active_mask !== 8'h08 || pending_any !== 1'b0) begin
         mismatched++;
         $display("FAIL single_after: change=%b mask=%h pend=%b, required 0/08/0", change, active_mask, pending_any);
      end
   endtask

   task automatic test_simultaneous();
      int exp_id[3];
      int net;
`ifdef IOT_ARB_RR_EN
      exp_id = '{5, 6, 1};
`else
      exp_id = '{1, 5, 6};
`endif
      net = 0;
      settle();
      for (int phase = 0; phase < 2; phase++) begin
         dev_on = (phase == 0) ? 8'h62 : 8'h00;
         tick();
         for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (change !== 1'b1 || on_off !== (phase == 0) || dev_id !== dev_id_t'(exp_id[k])) begin
               mismatched++;
               $display("FAIL simult_p%0d[%0d]: change=%b on_off=%b dev_id=%0d, required 1/%0d/%0d",
                        phase, k, change, on_off, dev_id, (phase == 0), exp_id[k]);
            end
            if (change) net += on_off ? 1 : -1;
         end
         tick();
         compared++;
         if (change !== 1'b0 || active_mask !== ((phase == 0) ? 8'h62 : 8'h00)) begin
            mismatched++;
            $display("FAIL simult_end_p%0d: change=%b mask=%h", phase, change, active_mask);
         end
      end
      compared++;
      if (net !== 0) begin
         mismatched++;
         $display("FAIL simult_net: got %0d, required 0", net);
      end
   endtask

   task automatic test_glitch();
      settle();
      en = 1'b0;
      dev_on = 8'h04;
      tick();
      compared++;
      if (pending_any !== 1'b1 || change !== 1'b0) begin
         mismatched++;
         $display("FAIL glitch_hold: pend=%b change=%b, required 1/0", pending_any, change);
      end
      dev_on = 8'h00;
      tick();
      compared++;
      if (pending_any !== 1'b0) begin
         mismatched++;
         $display("FAIL glitch_cancel: pend=%b, required 0", pending_any);
      end
      en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         compared++;
         if (change !== 1'b0 || active_mask !== 8'h00) begin
            mismatched++;
            $display("FAIL glitch_no_event[%0d]: change=%b mask=%h, required 0/00", i, change, active_mask);
         end
      end
   endtask

   task automatic test_policy();
      int exp_id[2];
`ifdef IOT_ARB_RR_EN
      exp_id = '{6, 2};
`else
      exp_id = '{2, 6};
`endif
      settle();
      dev_on = 8'h20;
      tick(); tick();
      compared++;
      if (change !== 1'b1 || dev_id !== 3'd5) begin
         mismatched++;
         $display("FAIL policy_first: change=%b dev_id=%0d, required 1/5", change, dev_id);
      end
      tick();
      dev_on = 8'h64;
      tick();
      for (int k = 0; k < 2; k++) begin
         tick();
         compared++;
         if (change !== 1'b1 || on_off !== 1'b1 || dev_id !== dev_id_t'(exp_id[k])) begin
            mismatched++;
            $display("FAIL policy_order[%0d]: change=%b on_off=%b dev_id=%0d, required 1/1/%0d",
                     k, change, on_off, dev_id, exp_id[k]);
         end
      end
      tick();
      compared++;
      if (change !== 1'b0 || active_mask !== 8'h64) begin
         mismatched++;
         $display("FAIL policy_end: change=%b mask=%h, required 0/64", change, active_mask);
      end
   endtask

   task automatic test_soak();
      logic [7:0] count;
      int         fails;
      fails = 0;
      count = 8'd0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         dev_on = dev_mask_t'($urandom);
         en     = ($urandom_range(0, 3) != 0);
         tick();
         if (change) count = on_off ? count + 8'd1 : count - 8'd1;
         compared++;
         if (count !== 8'($countones(active_mask))) begin
            mismatched++;
            fails++;
            if (fails <= 10)
               $display("FAIL soak_invariant[%0d]: counter=%0d popcount=%0d", c, count, $countones(active_mask));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_glitch();
      test_policy();
      test_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
